uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter with an integrated FIFO. It is the successor to the fixed 8N1 TX path in the full-duplex UART. Data width, parity, stop-bit count and FIFO depth are compile-time options. Adds a transmit-enable gate, back-to-back framing, an overflow flag and an occupancy count. It sits between the host write interface and the tx_pin pad.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 19200, line rate; bit period DIV = CLK_FREQ/BAUD_RATE clocks (integer division; elaboration error if DIV < 2)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, entries; power of 2, >= 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
trans_start  in  1  write strobe; pushes data_in when FIFO not full
data_in  in  DATA_BITS  payload to queue
tx_enable  in  1  1 = frames may start; 0 = hold queued data
tx_pin  out  1  serial line, idle high
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_empty  out  1  FIFO holds 0 entries
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
tx_busy  out  1  high from start bit through last stop bit
overflow  out  1  sticky; set by a write while full; cleared only by reset
transmission_complete  out  1  one-cycle pulse on the last cycle of each frame's stop period

Behaviour:
- Reset (rst=0, async): tx_pin=1, fifo_empty=1, fifo_full=0, fifo_count=0, tx_busy=0, overflow=0, transmission_complete=0; pointers 0, FSM=IDLE, baud counter 0.
- FIFO write:
  - trans_start && !fifo_full writes at rising edge; wr_ptr increments modulo FIFO_DEPTH.
  - trans_start && fifo_full drops the data and sets overflow. fifo_full is the registered value; a same-cycle pop does not make room.
- FIFO read: a pop occurs only from the FSM. Simultaneous push and pop leave the count unchanged.
- Baud counter counts 0..DIV-1 while tx_busy. It reloads at each bit boundary.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: if !fifo_empty && tx_enable, latch mem[rd_ptr] into the shift register, pop, and go to START.
  - START: tx_pin=0 for DIV cycles, then DATA.
  - DATA: shift LSB first, DATA_BITS x DIV cycles. Next state is PARITY if PARITY!=0, else STOP.
  - PARITY: even parity bit = XOR of data; odd parity bit = its inverse; DIV cycles.
  - STOP: tx_pin=1 for STOP_BITS x DIV cycles. On the last cycle, pulse transmission_complete. If !fifo_empty && tx_enable on that cycle, latch, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Latency: a write into an empty FIFO with idle FSM at edge N appears in the FIFO at N; the FSM pops at edge N+1; tx_pin falls after edge N+1.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) x DIV cycles.
- tx_busy=1 from the START entry edge until the IDLE entry edge.
- tx_pin is registered and glitch-free.
- tx_enable falling mid-frame: the current frame completes fully; no new frame starts.
- Data of DATA_BITS=9 is carried fully. The FIFO width equals DATA_BITS.
- Reset mid-frame: immediately tx_pin=1, the FIFO is flushed, and no complete pulse is issued.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - tx_state_e enum
  - function calc_parity(data, mode)
  - localparam helper for DIV
- Sub-module uart_tx_fifo: parametrised width/depth synchronous FIFO with count, full, empty and combinational dout = mem[rd_ptr].

Test Plan:
1. CLK_FREQ=16, BAUD_RATE=1 (DIV=16), 8N1. Write 0xA5 -> tx_pin low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. Complete pulse at cycle 160 after the start edge.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2. Write 0x53 -> data bits 1,1,0,0,1,0,1, parity bit 0, stop high 32 cycles. Frame 176 cycles.
3. FIFO_DEPTH=4, tx_enable=0. Write 5 words -> fifo_full after 4, fifo_count=4, overflow=1, 5th word never transmitted. Raise tx_enable -> 4 frames sent back-to-back with no idle gap, 4 complete pulses.
4. Frame in progress, drop tx_enable at mid data bit 3 with 2 words queued -> the frame finishes; tx_pin stays high; fifo_count stays 2 until re-enable.
5. Assert rst=0 during DATA with 3 words queued -> tx_pin=1 asynchronously, fifo_count=0, tx_busy=0, no complete pulse, overflow=0.
6. Simultaneous trans_start and FSM pop with fifo_count=2 -> count stays 2 and data order is preserved (FIFO first-in first-out).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int MAX_DATA_BITS = 9;

   function automatic int calc_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Unused upper payload bits must be zero so they do not disturb the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input parity_e mode);
      case (mode)
         PAR_ODD:  return ~(^data);
         PAR_EVEN: return ^data;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; dout shows the head entry combinationally.
// Writes while full and reads while empty are ignored.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push, pop;

   always_comb begin
      push     = wr_en && (count_q != FULL_CNT);
      pop      = rd_en && (count_q != '0);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= din;
   end

   assign dout  = mem[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter fed by a FIFO; first start bit one cycle after the write.
// Writes while full are dropped and flagged; tx_enable low holds queued data between frames.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 19200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          trans_start,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          tx_enable,
   output logic                          tx_pin,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_busy,
   output logic                          overflow,
   output logic                          transmission_complete
);
   localparam int      DIV   = calc_div(CLK_FREQ, BAUD_RATE);
   localparam int      CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam parity_e PMODE = parity_e'(PARITY[1:0]);

   if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_param: illegal parameter combination");
   end

   tx_state_e            state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;
   logic                 baud_end, last_stop, can_load, load;
   logic [DATA_BITS-1:0] fifo_dout;

   uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .wr_en (trans_start),
      .din   (data_in),
      .rd_en (load),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q | (trans_start & fifo_full);
      baud_end  = (baud_q == CW'(DIV - 1));
      last_stop = (bit_q == 4'(STOP_BITS - 1));
      can_load  = !fifo_empty && tx_enable;
      load      = can_load && ((state_q == ST_IDLE) ||
                               (state_q == ST_STOP && baud_end && last_stop));

      if (state_q != ST_IDLE) baud_d = baud_end ? '0 : baud_q + CW'(1);

      case (state_q)
         ST_IDLE: ;
         ST_START: if (baud_end) begin
            state_d = ST_DATA;
            tx_d    = shift_q[0];
            bit_d   = '0;
         end
         ST_DATA: if (baud_end) begin
            if (bit_q == 4'(DATA_BITS - 1)) begin
               bit_d = '0;
               if (PMODE != PAR_NONE) begin
                  state_d = ST_PARITY;
                  tx_d    = par_q;
               end else begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end
            end else begin
               shift_d = shift_q >> 1;
               tx_d    = shift_q[1];
               bit_d   = bit_q + 4'd1;
            end
         end
         ST_PARITY: if (baud_end) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
            bit_d   = '0;
         end
         ST_STOP: begin
            // Registered pulse: raised one cycle early so it lands on the final stop cycle.
            if (last_stop && baud_q == CW'(DIV - 2)) done_d = 1'b1;
            if (baud_end) begin
               if (!last_stop) begin
                  bit_d = bit_q + 4'd1;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         state_d = ST_START;
         shift_d = fifo_dout;
         par_d   = calc_parity(MAX_DATA_BITS'(fifo_dout), PMODE);
         tx_d    = 1'b0;
         busy_d  = 1'b1;
         baud_d  = '0;
         bit_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign tx_pin                = tx_q;
   assign tx_busy               = busy_q;
   assign overflow              = ovf_q;
   assign transmission_complete = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: an 8N1 depth-4 instance and a 7E2 instance, both at 16 clocks per bit.
module tb_uart_tx_param;
   localparam int DIV = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       a_start = 1'b0, a_en = 1'b0;
   logic [7:0] a_data = '0;
   logic       a_tx, a_full, a_empty, a_busy, a_ovf, a_done;
   logic [2:0] a_count;

   logic       b_start = 1'b0, b_en = 1'b0;
   logic [6:0] b_data = '0;
   logic       b_tx, b_full, b_empty, b_busy, b_ovf, b_done;
   logic [3:0] b_count;

   uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .trans_start(a_start), .data_in(a_data), .tx_enable(a_en),
      .tx_pin(a_tx), .fifo_full(a_full), .fifo_empty(a_empty), .fifo_count(a_count),
      .tx_busy(a_busy), .overflow(a_ovf), .transmission_complete(a_done));

   uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(8)) dut_b (
      .clk(clk), .rst(rst), .trans_start(b_start), .data_in(b_data), .tx_enable(b_en),
      .tx_pin(b_tx), .fifo_full(b_full), .fifo_empty(b_empty), .fifo_count(b_count),
      .tx_busy(b_busy), .overflow(b_ovf), .transmission_complete(b_done));

   int total = 0;
   int bad   = 0;

   bit exp_tx[$], exp_done[$], cap_tx[$], cap_done[$], cap_busy[$];

   task automatic clear_wave();
      exp_tx.delete(); exp_done.delete();
      cap_tx.delete(); cap_done.delete(); cap_busy.delete();
   endtask

   // Reference frame: start, LSB-first payload, optional parity, stop bits; each bit DIV cycles.
   task automatic add_frame(input int data, input int nbits, input int par, input int stops);
      bit b[$];
      int ones = 0;
      b.push_back(1'b0);
      for (int i = 0; i < nbits; i++) begin
         b.push_back(bit'((data >> i) & 1));
         ones += (data >> i) & 1;
      end
      if (par == 2) b.push_back(bit'(ones % 2));
      if (par == 1) b.push_back(bit'(1 - ones % 2));
      for (int i = 0; i < stops; i++) b.push_back(1'b1);
      foreach (b[k])
         for (int c = 0; c < DIV; c++) begin
            exp_tx.push_back(b[k]);
            exp_done.push_back(1'b0);
         end
      exp_done[exp_done.size() - 1] = 1'b1;
   endtask

   task automatic cap_a(input int n);
      for (int i = 0; i < n; i++) begin
         cap_tx.push_back(a_tx); cap_done.push_back(a_done); cap_busy.push_back(a_busy);
         @(negedge clk);
      end
   endtask

   task automatic cap_b(input int n);
      for (int i = 0; i < n; i++) begin
         cap_tx.push_back(b_tx); cap_done.push_back(b_done); cap_busy.push_back(b_busy);
         @(negedge clk);
      end
   endtask

   function automatic int wave_diff(output int first);
      int n = 0;
      first = -1;
      for (int c = 0; c < exp_tx.size(); c++)
         if (c >= cap_tx.size() || cap_tx[c] !== exp_tx[c] ||
             cap_done[c] !== exp_done[c] || cap_busy[c] !== 1'b1) begin
            if (first < 0) first = c;
            n++;
         end
      return n;
   endfunction

   task automatic wait_low_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (a_tx === 1'b0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_low_b(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (b_tx === 1'b0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({a_tx, a_empty, a_full, a_count, a_busy, a_ovf, a_done} !== {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_a: got %b want 110000000", {a_tx, a_empty, a_full, a_count, a_busy, a_ovf, a_done});
      end
      total++;
      if ({b_tx, b_empty, b_full, b_count, b_busy, b_ovf, b_done} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_b: got %b want 1100000000", {b_tx, b_empty, b_full, b_count, b_busy, b_ovf, b_done});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_8n1();
      int d, f;
      a_en = 1'b1; a_data = 8'hA5; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      total++;
      if ({a_tx, a_count, a_busy} !== {1'b1, 3'd1, 1'b0}) begin
         bad++; $display("FAIL latency_queued: got %b want 10010", {a_tx, a_count, a_busy});
      end
      @(negedge clk);
      total++;
      if ({a_tx, a_count, a_busy} !== {1'b0, 3'd0, 1'b1}) begin
         bad++; $display("FAIL latency_start: got %b want 00001", {a_tx, a_count, a_busy});
      end
      clear_wave();
      add_frame(8'hA5, 8, 0, 1);
      cap_a(160);
      d = wave_diff(f);
      total++;
      if (d !== 0) begin
         bad++; $display("FAIL frame_a5: %0d cycles differ, first at %0d, want 0", d, f);
      end
      total++;
      if ({a_tx, a_busy, a_done} !== 3'b100) begin
         bad++; $display("FAIL idle_after_a5: got %b want 100", {a_tx, a_busy, a_done});
      end
   endtask

   task automatic test_parity_b();
      int w[3];
      bit ok;
      int d, f;
      w[0] = 'h53; w[1] = $urandom_range(0, 127); w[2] = $urandom_range(0, 127);
      b_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         b_data = 7'(w[k]); b_start = 1'b1;
         @(negedge clk);
         b_start = 1'b0;
         wait_low_b(ok);
         total++;
         if (ok !== 1'b1) begin bad++; $display("FAIL start_b%0d: no start bit, want one", k); end
         clear_wave();
         add_frame(w[k], 7, 2, 2);
         cap_b(176);
         d = wave_diff(f);
         total++;
         if (d !== 0) begin
            bad++; $display("FAIL frame_7e2 data=%h: %0d cycles differ, first at %0d, want 0", w[k], d, f);
         end
         total++;
         if ({b_tx, b_busy, b_count} !== {1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL idle_b%0d: got %b want 100000", k, {b_tx, b_busy, b_count});
         end
      end
   endtask

   task automatic test_overflow_a();
      int w[5];
      bit ok;
      int d, f;
      a_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w[i] = $urandom_range(0, 255);
         a_data = 8'(w[i]); a_start = 1'b1;
         @(negedge clk);
         if (i == 3) begin
            total++;
            if ({a_full, a_count, a_ovf} !== {1'b1, 3'd4, 1'b0}) begin
               bad++; $display("FAIL full_after_4: got %b want 11000", {a_full, a_count, a_ovf});
            end
         end
      end
      a_start = 1'b0;
      total++;
      if ({a_full, a_empty, a_count, a_ovf, a_tx} !== {1'b1, 1'b0, 3'd4, 1'b1, 1'b1}) begin
         bad++; $display("FAIL overflow_flag: got %b want 1010011", {a_full, a_empty, a_count, a_ovf, a_tx});
      end
      a_en = 1'b1;
      wait_low_a(ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL start_ovf: no start bit, want one"); end
      clear_wave();
      for (int i = 0; i < 4; i++) add_frame(w[i], 8, 0, 1);
      cap_a(640);
      d = wave_diff(f);
      total++;
      if (d !== 0) begin
         bad++; $display("FAIL back_to_back_4: %0d cycles differ, first at %0d, want 0", d, f);
      end
      total++;
      if ({a_tx, a_busy, a_empty, a_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
         bad++; $display("FAIL drained: got %b want 101000", {a_tx, a_busy, a_empty, a_count});
      end
   endtask

   task automatic test_enable_drop();
      int w[3];
      bit ok;
      int d, f, lows;
      a_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w[i] = $urandom_range(0, 255);
         a_data = 8'(w[i]); a_start = 1'b1;
         @(negedge clk);
      end
      a_start = 1'b0;
      a_en = 1'b1;
      wait_low_a(ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL start_drop: no start bit, want one"); end
      clear_wave();
      add_frame(w[0], 8, 0, 1);
      cap_a(72);
      a_en = 1'b0;
      cap_a(88);
      d = wave_diff(f);
      total++;
      if (d !== 0) begin
         bad++; $display("FAIL frame_after_drop: %0d cycles differ, first at %0d, want 0", d, f);
      end
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         if (a_tx !== 1'b1 || a_count !== 3'd2 || a_busy !== 1'b0) lows++;
         @(negedge clk);
      end
      total++;
      if (lows !== 0) begin
         bad++; $display("FAIL hold_disabled: %0d cycles active or count changed, want 0", lows);
      end
      a_en = 1'b1;
      wait_low_a(ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL start_reenable: no start bit, want one"); end
      clear_wave();
      add_frame(w[1], 8, 0, 1);
      add_frame(w[2], 8, 0, 1);
      cap_a(320);
      d = wave_diff(f);
      total++;
      if (d !== 0) begin
         bad++; $display("FAIL frames_reenable: %0d cycles differ, first at %0d, want 0", d, f);
      end
   endtask

   task automatic test_simul_push_pop();
      int w[4];
      bit ok;
      int d, f;
      a_en = 1'b0;
      for (int i = 0; i < 4; i++) w[i] = $urandom_range(0, 255);
      for (int i = 0; i < 3; i++) begin
         a_data = 8'(w[i]); a_start = 1'b1;
         @(negedge clk);
      end
      a_start = 1'b0;
      a_en = 1'b1;
      wait_low_a(ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL start_simul: no start bit, want one"); end
      clear_wave();
      for (int i = 0; i < 4; i++) add_frame(w[i], 8, 0, 1);
      cap_a(159);
      a_data = 8'(w[3]); a_start = 1'b1;
      cap_a(1);
      a_start = 1'b0;
      total++;
      if (a_count !== 3'd2) begin
         bad++; $display("FAIL push_pop_count: got %0d want 2", a_count);
      end
      cap_a(480);
      d = wave_diff(f);
      total++;
      if (d !== 0) begin
         bad++; $display("FAIL push_pop_order: %0d cycles differ, first at %0d, want 0", d, f);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int act;
      a_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_data = 8'($urandom_range(0, 255)); a_start = 1'b1;
         @(negedge clk);
      end
      a_start = 1'b0;
      a_en = 1'b1;
      wait_low_a(ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL start_rstmid: no start bit, want one"); end
      repeat (40) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++;
      if ({a_tx, a_busy, a_done, a_count, a_empty, a_full, a_ovf} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL async_reset: got %b want 100000100", {a_tx, a_busy, a_done, a_count, a_empty, a_full, a_ovf});
      end
      act = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (a_done !== 1'b0 || a_tx !== 1'b1) act++;
      end
      rst = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (a_done !== 1'b0 || a_tx !== 1'b1 || a_busy !== 1'b0) act++;
      end
      total++;
      if (act !== 0) begin
         bad++; $display("FAIL flushed_quiet: %0d active cycles after reset, want 0", act);
      end
   endtask

   initial begin
      test_reset();
      test_single_8n1();
      test_parity_b();
      test_overflow_a();
      test_enable_drop();
      test_simul_push_pop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
